ex_mem_stage: RTL

Pipeline register and branch-resolution stage between the 16-bit execute ALU and data memory in the pipelined CPU. It captures the ALU result `C`, the ALU `Flag` and the instruction control bits once per cycle. It resolves conditional branches from the flag and raises a one-cycle redirect pulse. It also holds the halt state machine and a retired-instruction counter.

---
 rtl/ex_mem_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, halt FSM and retired-instruction counter.
// Optional execute-stage forwarding outputs are enabled by defining EXMEM_FWD_EN.
`timescale 1ns/1ps
module ex_mem_stage #(
  parameter int WIDTH = 16,
  parameter int RF_AW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_flag,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_target,
  input  logic             in_is_branch,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic             in_reg_write,
  input  logic             in_halt,
  input  logic [RF_AW-1:0] in_dest,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_b,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_reg_write,
  output logic [RF_AW-1:0] out_dest,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target,
  output logic             halted,
  output logic [15:0]      num_inst
`ifdef EXMEM_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [RF_AW-1:0] fwd_dest,
  output logic [WIDTH-1:0] fwd_data
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             vld_p1;
  logic [WIDTH-1:0] c_p1;
  logic [WIDTH-1:0] b_p1;
  logic             ld_p1;
  logic             st_p1;
  logic             rw_p1;
  logic [RF_AW-1:0] dest_p1;
  logic             bt_p1;
  logic [WIDTH-1:0] tgt_p1;
  logic [15:0]      cnt_p1;

  logic shadow;
  logic accept;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The instruction presented while a redirect is being signalled is wrong-path.
  assign shadow   = bt_p1;
  assign in_ready = !stall && (state_q == RUN) && !shadow;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && in_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // EX -> MEM capture (p1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      c_p1    <= '0;
      b_p1    <= '0;
      ld_p1   <= 1'b0;
      st_p1   <= 1'b0;
      rw_p1   <= 1'b0;
      dest_p1 <= '0;
      bt_p1   <= 1'b0;
      tgt_p1  <= '0;
      cnt_p1  <= '0;
    end else if (stall) begin
      bt_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      c_p1    <= in_c;
      b_p1    <= in_b;
      ld_p1   <= in_is_load;
      st_p1   <= in_is_store;
      rw_p1   <= in_reg_write;
      dest_p1 <= in_dest;
      bt_p1   <= in_is_branch && in_flag;
      tgt_p1  <= in_target;
      cnt_p1  <= sat_inc(cnt_p1);
    end else begin
      vld_p1 <= 1'b0;
      bt_p1  <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign out_c         = c_p1;
  assign out_b         = b_p1;
  assign out_is_load   = ld_p1;
  assign out_is_store  = st_p1;
  assign out_reg_write = rw_p1;
  assign out_dest      = dest_p1;
  assign branch_taken  = bt_p1;
  assign branch_target = tgt_p1;
  assign halted        = (state_q == HALTED);
  assign num_inst      = cnt_p1;

`ifdef EXMEM_FWD_EN
  // Loads are excluded: their value only exists after the memory read.
  assign fwd_valid = vld_p1 && rw_p1 && !ld_p1;
  assign fwd_dest  = dest_p1;
  assign fwd_data  = c_p1;
`endif

endmodule
